mem_responder: RTL and testbench

Line-granular backing memory that answers the data cache's memory request interface. Writes (evictions) are accepted and committed in one cycle. Reads (line fills) are queued and answered after a fixed latency with line data plus line address. Each response is held until the cache acknowledges it. The block sits directly below the cache and serves as the system memory model for simulation and FPGA bring-up.

---
 rtl/mem_pkg.sv | 5 +
 rtl/line_fifo.sv | 38 +++
 rtl/mem_responder.sv | 90 +++++++++
 tb/tb_mem_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: request and response-state types shared by the memory responder
package mem_pkg;
  typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_req_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_e;
endpackage

// File: rtl/line_fifo.sv
// line_fifo: circular-pointer FIFO with count; push into a full FIFO only succeeds alongside a pop
module line_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign dout    = store[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) store[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: line memory answering cache fills after a fixed latency; MEM_RESP_ERR_EN adds sticky o_err
module mem_responder
  import mem_pkg::*;
#(
  parameter int N_ELEMENTS  = 4,
  parameter int N_BYTES     = 4,
  parameter int PA_WIDTH    = 32,
  parameter int N_LINES     = 256,
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 2,
  localparam int OFFSET_WIDTH   = $clog2(N_ELEMENTS),
  localparam int LINE_WIDTH     = N_ELEMENTS * N_BYTES * 8,
  localparam int LINE_IDX_WIDTH = $clog2(N_LINES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_enable,
  input  logic                  i_req_type,
  input  logic [PA_WIDTH-1:0]   i_req_addr,
  input  logic [LINE_WIDTH-1:0] i_req_data,
  input  logic                  i_ack,
  output logic                  o_resp_enable,
  output logic [PA_WIDTH-1:0]   o_resp_addr,
  output logic [LINE_WIDTH-1:0] o_resp_data,
  output logic                  o_full
`ifdef MEM_RESP_ERR_EN
  ,
  output logic                  o_err
`endif
);
  localparam int CNW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [PA_WIDTH-1:0] OFF_MASK = PA_WIDTH'(N_ELEMENTS - 1);
  logic [LINE_WIDTH-1:0] mem [N_LINES];
  logic [PA_WIDTH-1:0] head;
  logic [CNW-1:0] cnt, cnt_d;
  resp_state_e state, state_d;
  logic wr_req, rd_req, empty, load, pop;
  assign wr_req = i_req_enable && mem_req_e'(i_req_type) == MEM_WRITE;
  assign rd_req = i_req_enable && mem_req_e'(i_req_type) == MEM_READ;
  line_fifo #(.WIDTH(PA_WIDTH), .DEPTH(QUEUE_DEPTH)) rd_q (
    .clk(clk), .rst(rst), .push(rd_req), .pop(pop),
    .din(i_req_addr & ~OFF_MASK), .dout(head), .full(o_full), .empty(empty)
  );
  always_ff @(posedge clk)
    if (wr_req) mem[i_req_addr[OFFSET_WIDTH +: LINE_IDX_WIDTH]] <= i_req_data;
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        state_d = WAIT;
        cnt_d   = CNW'(LATENCY - 1);
      end
      WAIT: begin
        load    = cnt == '0;
        state_d = load ? RESP : WAIT;
        cnt_d   = load ? cnt : cnt - 1'b1;
      end
      RESP: begin
        pop     = i_ack;
        state_d = i_ack ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      o_resp_enable <= 1'b0;
      o_resp_addr   <= '0;
      o_resp_data   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load) begin
        o_resp_enable <= 1'b1;
        o_resp_addr   <= head;
        o_resp_data   <= mem[head[OFFSET_WIDTH +: LINE_IDX_WIDTH]];
      end else if (pop) o_resp_enable <= 1'b0;
    end
`ifdef MEM_RESP_ERR_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) o_err <= 1'b0;
    else if ((rd_req && o_full && !pop) || (i_ack && state != RESP) ||
             (i_req_enable && |(i_req_addr & OFF_MASK))) o_err <= 1'b1;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder (checks o_err when MEM_RESP_ERR_EN is defined)
module tb_mem_responder;
  localparam int LW = 128;
  localparam int AW = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic i_req_enable = 1'b0, i_req_type = 1'b0, i_ack = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic [LW-1:0] i_req_data = '0;
  logic o_resp_enable, o_full;
  logic [AW-1:0] o_resp_addr;
  logic [LW-1:0] o_resp_data;
`ifdef MEM_RESP_ERR_EN
  logic o_err;
`endif
  int checks = 0, errors = 0, n;
  localparam logic [LW-1:0] PA5 = {16{8'hA5}};
  localparam logic [LW-1:0] P5A = {16{8'h5A}};
  localparam logic [LW-1:0] P11 = {16{8'h11}};
  localparam logic [LW-1:0] P77 = {16{8'h77}};
  localparam logic [LW-1:0] P80 = {16{8'h80}};
  localparam logic [LW-1:0] PC0 = {16{8'hC0}};
  mem_responder dut (
    .clk(clk), .rst(rst), .i_req_enable(i_req_enable), .i_req_type(i_req_type),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_ack(i_ack),
    .o_resp_enable(o_resp_enable), .o_resp_addr(o_resp_addr),
    .o_resp_data(o_resp_data), .o_full(o_full)
`ifdef MEM_RESP_ERR_EN
    , .o_err(o_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    i_req_enable = 1'b1;
    i_req_type = wr;
    i_req_addr = a;
    i_req_data = d;
    tick();
    i_req_enable = 1'b0;
  endtask
  task automatic wait_resp(output int cycles, input int lim);
    cycles = 0;
    while (!o_resp_enable && cycles < lim) begin
      tick();
      cycles++;
    end
  endtask
  task automatic ack();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_en", LW'(o_resp_enable), 0);
    chk("rst_addr", LW'(o_resp_addr), 0);
    chk("rst_data", o_resp_data, 0);
    chk("rst_full", LW'(o_full), 0);
`ifdef MEM_RESP_ERR_EN
    chk("rst_err", LW'(o_err), 0);
`endif
    rst = 1'b0;
    tick();
    req(1'b1, 32'h40, PA5);
    req(1'b0, 32'h40, '0);
    wait_resp(n, 20);
    chk("t1_latency", LW'(n), 5);
    chk("t1_data", o_resp_data, PA5);
    chk("t1_addr", LW'(o_resp_addr), 32'h40);
    ack();
    chk("t1_ack_clear", LW'(o_resp_enable), 0);
    req(1'b1, 32'h80, P80);
    req(1'b1, 32'hC0, PC0);
    req(1'b0, 32'h80, '0);
    chk("t2_full_one", LW'(o_full), 0);
    req(1'b0, 32'hC0, '0);
    chk("t2_full_two", LW'(o_full), 1);
    wait_resp(n, 20);
    chk("t2_first_latency", LW'(n), 4);
    chk("t2_first_addr", LW'(o_resp_addr), 32'h80);
    chk("t2_first_data", o_resp_data, P80);
    tick();
    chk("t2_first_hold", LW'(o_resp_enable), 1);
    ack();
    chk("t2_ack_clear", LW'(o_resp_enable), 0);
    chk("t2_full_after_pop", LW'(o_full), 0);
    wait_resp(n, 20);
    chk("t2_second_latency", LW'(n), 5);
    chk("t2_second_addr", LW'(o_resp_addr), 32'hC0);
    chk("t2_second_data", o_resp_data, PC0);
    tick();
    ack();
    req(1'b0, 32'h40, '0);
    req(1'b0, 32'h80, '0);
    req(1'b0, 32'hC0, '0);
    chk("t3_full", LW'(o_full), 1);
`ifdef MEM_RESP_ERR_EN
    chk("t3_err", LW'(o_err), 1);
`endif
    wait_resp(n, 20);
    chk("t3_r1_addr", LW'(o_resp_addr), 32'h40);
    ack();
    wait_resp(n, 20);
    chk("t3_r2_addr", LW'(o_resp_addr), 32'h80);
    ack();
    wait_resp(n, 30);
    chk("t3_no_third", LW'(o_resp_enable), 0);
    req(1'b1, 32'h100, P11);
    req(1'b0, 32'h100, '0);
    tick();
    req(1'b1, 32'h100, P5A);
    wait_resp(n, 20);
    chk("t4_wait_write", o_resp_data, P5A);
    chk("t4_addr", LW'(o_resp_addr), 32'h100);
    req(1'b1, 32'h100, P77);
    chk("t4_resp_write_held", o_resp_data, P5A);
    ack();
    req(1'b0, 32'h40, '0);
    wait_resp(n, 20);
    chk("t5_pre_rst_en", LW'(o_resp_enable), 1);
    rst = 1'b1;
    tick();
    chk("t5_rst_en", LW'(o_resp_enable), 0);
    chk("t5_rst_addr", LW'(o_resp_addr), 0);
    chk("t5_rst_data", o_resp_data, 0);
    chk("t5_rst_full", LW'(o_full), 0);
`ifdef MEM_RESP_ERR_EN
    chk("t5_rst_err", LW'(o_err), 0);
`endif
    rst = 1'b0;
    wait_resp(n, 30);
    chk("t5_no_reissue", LW'(o_resp_enable), 0);
    req(1'b0, 32'h100, '0);
    wait_resp(n, 20);
    chk("t5_retained_data", o_resp_data, P77);
    ack();
    req(1'b0, 32'hC0, '0);
    wait_resp(n, 20);
    for (int i = 0; i < 20; i++) begin
      chk("t6_hold_en", LW'(o_resp_enable), 1);
      chk("t6_hold_addr", LW'(o_resp_addr), 32'hC0);
      chk("t6_hold_data", o_resp_data, PC0);
      tick();
    end
    ack();
    chk("t6_ack_clear", LW'(o_resp_enable), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
